// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: pointer
// width limits and Gray-code helpers.
package async_fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int PTR_MAX_W = 9;

  typedef struct packed {
    logic full;
    logic afull;
    logic ovf;
  } wr_flags_t;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(
    input logic [PTR_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(
    input logic [PTR_MAX_W-1:0] g
  );
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the async FIFO:
// pointers, full/almost-full, overflow.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  OVF_CLR,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic                  OVERFLOW,
  output logic [ADDR_WIDTH:0]   W_LEVEL
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  wr_flags_t     flags_q, flags_d;
  logic          w_en;

  assign w_en = W_INC & ~flags_q.full;

  always_comb begin
    wbin_d   = wbin_q + {{(PW-1){1'b0}}, w_en};
    wptr_d   = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    rbin     = PW'(gray2bin(PTR_MAX_W'(wq2_rptr)));
    level_d  = wbin_d - rbin;
    // Full when write Gray equals read Gray with top two bits flipped
    full_cmp = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    flags_d       = '0;
    flags_d.full  = (wptr_d == full_cmp);
    flags_d.afull = (level_d >= AF_T);
    flags_d.ovf   = (W_INC & flags_q.full)
                  | (flags_q.ovf & ~OVF_CLR);
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      flags_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      flags_q <= flags_d;
    end
  end

  assign W_EN        = w_en;
  assign w_addr      = wbin_q[ADDR_WIDTH-1:0];
  assign w_ptr       = wptr_q;
  assign W_LEVEL     = level_q;
  assign FULL        = flags_q.full;
  assign ALMOST_FULL = flags_q.afull;
  assign OVERFLOW    = flags_q.ovf;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed
// vector table plus randomized model check.
module tb_async_fifo_wr_ctrl;

  logic       W_CLK = 1'b0;
  logic       W_RST;
  logic       W_INC;
  logic [3:0] wq2_rptr;
  logic       OVF_CLR;
  logic       W_EN;
  logic [2:0] w_addr;
  logic [3:0] w_ptr;
  logic       FULL;
  logic       ALMOST_FULL;
  logic       OVERFLOW;
  logic [3:0] W_LEVEL;

  async_fifo_wr_ctrl #(
    .ADDR_WIDTH(3),
    .AFULL_THRESH(6)
  ) dut (
    .W_CLK(W_CLK),
    .W_RST(W_RST),
    .W_INC(W_INC),
    .wq2_rptr(wq2_rptr),
    .OVF_CLR(OVF_CLR),
    .W_EN(W_EN),
    .w_addr(w_addr),
    .w_ptr(w_ptr),
    .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL),
    .OVERFLOW(OVERFLOW),
    .W_LEVEL(W_LEVEL)
  );

  always #5 W_CLK = ~W_CLK;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       inc;
    logic       clr;
    logic [3:0] rptr;
    logic       wen;
    logic       full;
    logic       afull;
    logic       ovf;
    logic [3:0] level;
    logic [3:0] wptr;
    logic [2:0] addr;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(
    input logic i, input logic c, input logic [3:0] r,
    input logic we, input logic f, input logic af,
    input logic o, input logic [3:0] l,
    input logic [3:0] p, input logic [2:0] a);
    vec_t v;
    v.inc = i; v.clr = c; v.rptr = r;
    v.wen = we; v.full = f; v.afull = af; v.ovf = o;
    v.level = l; v.wptr = p; v.addr = a;
    return v;
  endfunction

  // Reference model: counts of words written and read.
  int m_w;
  int m_lvl;
  bit m_full;
  bit m_afull;
  bit m_ovf;

  function automatic int g2b(input int g);
    for (int b = 0; b < 16; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return 0;
  endfunction

  function automatic logic [3:0] b2g(input int b);
    int x;
    x = b % 16;
    return 4'(x ^ (x >> 1));
  endfunction

  task automatic model_reset();
    m_w = 0; m_lvl = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic cyc(input bit inc, input int rcnt,
                     input bit clr);
    W_INC = inc;
    OVF_CLR = clr;
    wq2_rptr = b2g(rcnt);
    #1;
    chk("w_en", W_EN, inc && !m_full);
    @(posedge W_CLK);
    #1;
    if (inc && !m_full) m_w = (m_w + 1) % 16;
    m_ovf = (inc && m_full) || (m_ovf && !clr);
    m_lvl = (m_w - g2b(b2g(rcnt)) + 16) % 16;
    m_full = (m_lvl == 8);
    m_afull = (m_lvl >= 6);
    chk("level", W_LEVEL, m_lvl);
    chk("full", FULL, m_full);
    chk("afull", ALMOST_FULL, m_afull);
    chk("ovf", OVERFLOW, m_ovf);
    chk("w_ptr", w_ptr, b2g(m_w));
    chk("w_addr", w_addr, m_w % 8);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wptr"}, w_ptr, 0);
    chk({tag, "_addr"}, w_addr, 0);
    chk({tag, "_level"}, W_LEVEL, 0);
    chk({tag, "_full"}, FULL, 0);
    chk({tag, "_afull"}, ALMOST_FULL, 0);
    chk({tag, "_ovf"}, OVERFLOW, 0);
    chk({tag, "_wen"}, W_EN, W_INC);
  endtask

  initial begin
    int r;
    tbl[0]  = mk(1,0,4'd0, 1,0,0,0, 4'd1, 4'd1,  3'd1);
    tbl[1]  = mk(1,0,4'd0, 1,0,0,0, 4'd2, 4'd3,  3'd2);
    tbl[2]  = mk(1,0,4'd0, 1,0,0,0, 4'd3, 4'd2,  3'd3);
    tbl[3]  = mk(1,0,4'd0, 1,0,0,0, 4'd4, 4'd6,  3'd4);
    tbl[4]  = mk(1,0,4'd0, 1,0,0,0, 4'd5, 4'd7,  3'd5);
    tbl[5]  = mk(1,0,4'd0, 1,0,1,0, 4'd6, 4'd5,  3'd6);
    tbl[6]  = mk(1,0,4'd0, 1,0,1,0, 4'd7, 4'd4,  3'd7);
    tbl[7]  = mk(1,0,4'd0, 1,1,1,0, 4'd8, 4'd12, 3'd0);
    tbl[8]  = mk(1,0,4'd0, 0,1,1,1, 4'd8, 4'd12, 3'd0);
    tbl[9]  = mk(0,1,4'd0, 0,1,1,0, 4'd8, 4'd12, 3'd0);
    tbl[10] = mk(1,1,4'd0, 0,1,1,1, 4'd8, 4'd12, 3'd0);
    tbl[11] = mk(0,1,4'd0, 0,1,1,0, 4'd8, 4'd12, 3'd0);
    tbl[12] = mk(0,0,4'd3, 0,0,1,0, 4'd6, 4'd12, 3'd0);
    tbl[13] = mk(1,0,4'd3, 1,0,1,0, 4'd7, 4'd13, 3'd1);
    tbl[14] = mk(1,0,4'd3, 1,1,1,0, 4'd8, 4'd15, 3'd2);

    W_RST = 1'b0;
    W_INC = 1'b0;
    OVF_CLR = 1'b0;
    wq2_rptr = 4'd0;
    #12;
    chk_zero("rst0");
    @(negedge W_CLK);
    W_RST = 1'b1;
    @(posedge W_CLK);
    #1;

    // Directed fill / overflow / clear / drain vectors
    foreach (tbl[i]) begin
      W_INC = tbl[i].inc;
      OVF_CLR = tbl[i].clr;
      wq2_rptr = tbl[i].rptr;
      #1;
      chk($sformatf("t%0d_wen", i), W_EN, tbl[i].wen);
      @(posedge W_CLK);
      #1;
      chk($sformatf("t%0d_full", i), FULL, tbl[i].full);
      chk($sformatf("t%0d_afull", i), ALMOST_FULL,
          tbl[i].afull);
      chk($sformatf("t%0d_ovf", i), OVERFLOW, tbl[i].ovf);
      chk($sformatf("t%0d_level", i), W_LEVEL, tbl[i].level);
      chk($sformatf("t%0d_wptr", i), w_ptr, tbl[i].wptr);
      chk($sformatf("t%0d_addr", i), w_addr, tbl[i].addr);
    end

    // Mid-stream asynchronous reset while full
    W_INC = 1'b1;
    #2;
    W_RST = 1'b0;
    #1;
    chk_zero("rst_mid");
    #1;
    W_RST = 1'b1;
    model_reset();
    cyc(1, 0, 0);
    chk("resume_wptr", w_ptr, 4'b0001);

    // Wrap: reader keeps pace, 16 more accepted writes
    for (int i = 0; i < 16; i++) cyc(1, m_w, 0);
    chk("wrap_wptr", w_ptr, 4'b0001);
    for (int i = 0; i < 15; i++) cyc(1, m_w, 0);
    chk("wrap_zero", w_ptr, 4'b0000);
    chk("wrap_addr", w_addr, 3'd0);

    // Randomized traffic with a lagging reader
    W_RST = 1'b0;
    #1;
    W_RST = 1'b1;
    model_reset();
    r = 0;
    for (int i = 0; i < 500; i++) begin
      if (r != m_w && $urandom_range(0, 2) == 0)
        r = (r + 1) % 16;
      cyc($urandom_range(0, 3) != 0, r,
          $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
